// File: rtl/capture_sequencer.sv
// capture_sequencer: arms and sequences repeated capture-buffer shots on pdh_clk.
// Optional WAIT_DONE watchdog is compiled in when CAPTURE_SEQ_TIMEOUT_EN is defined.
module capture_sequencer #(
  parameter int unsigned TRIG_W = 14,
  parameter int unsigned HOLD_W = 32,
  parameter int unsigned SHOT_W = 8
) (
  input  logic                     pdh_clk,
  input  logic                     rst_ni,
  input  logic                     arm_i,
  input  logic                     abort_i,
  input  logic [1:0]               mode_i,
  input  logic signed [TRIG_W-1:0] trig_sample_i,
  input  logic signed [TRIG_W-1:0] trig_level_i,
  input  logic [SHOT_W-1:0]        shots_i,
  input  logic [HOLD_W-1:0]        holdoff_i,
  input  logic [HOLD_W-1:0]        timeout_i,
  input  logic                     capture_done_i,
  output logic                     capture_enable_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [SHOT_W-1:0]        shots_done_o,
  output logic                     error_o,
  output logic [2:0]               state_o
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ARMED    = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_HOLDOFF  = 3'd3;
  localparam logic [2:0] S_FINISHED = 3'd4;

  localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [SHOT_W-1:0] SHOT_ONE = {{(SHOT_W-1){1'b0}}, 1'b1};

  logic [2:0]               state_q, state_d;
  logic                     arm_q, cdone_q;
  logic signed [TRIG_W-1:0] prev_q, level_q;
  logic [1:0]               mode_q;
  logic [SHOT_W-1:0]        shots_q, cnt_q, cnt_d, cnt_inc;
  logic [HOLD_W-1:0]        hold_q, hcnt_q, hcnt_d;
  logic                     en_q, en_d, done_q, done_d, busy_q, busy_d;
  logic                     latch, trig, arm_edge, done_edge;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic [HOLD_W-1:0]        tmo_q, wcnt_q, wcnt_d;
  logic                     err_q, err_d;
`else
  logic                     timeout_unused;
  assign timeout_unused = ^timeout_i;
`endif

  assign arm_edge  = arm_i & ~arm_q;
  // A done level still high from the previous shot never produces an edge here.
  assign done_edge = capture_done_i & ~cdone_q;
  assign cnt_inc   = cnt_q + SHOT_ONE;

  always_comb begin
    case (mode_q)
      2'd1:    trig = (prev_q < level_q) && (trig_sample_i >= level_q);
      2'd2:    trig = (prev_q > level_q) && (trig_sample_i <= level_q);
      default: trig = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    latch   = 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    err_d   = err_q;
    wcnt_d  = wcnt_q;
`endif
    if (abort_i) begin
      state_d = S_IDLE;
      en_d    = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FINISHED: begin
          if (arm_edge) begin
            latch   = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b0;
            state_d = S_ARMED;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            err_d   = 1'b0;
`endif
          end
        end
        S_ARMED: begin
          if (trig) begin
            en_d    = 1'b1;
            state_d = S_WAIT;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end
        end
        S_WAIT: begin
          if (done_edge) begin
            en_d  = 1'b0;
            cnt_d = cnt_inc;
            if ((shots_q != '0) && (cnt_inc == shots_q)) begin
              state_d = S_FINISHED;
              done_d  = 1'b1;
            end else if (hold_q == '0) begin
              state_d = S_ARMED;
            end else begin
              state_d = S_HOLDOFF;
              hcnt_d  = '0;
            end
          end
`ifdef CAPTURE_SEQ_TIMEOUT_EN
          else if ((tmo_q != '0) && (wcnt_q == tmo_q - HOLD_ONE)) begin
            en_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wcnt_d = wcnt_q + HOLD_ONE;
          end
`endif
        end
        S_HOLDOFF: begin
          if (hcnt_q == hold_q - HOLD_ONE) state_d = S_ARMED;
          else                             hcnt_d  = hcnt_q + HOLD_ONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_ARMED) || (state_d == S_WAIT) || (state_d == S_HOLDOFF);
  end

  always_ff @(posedge pdh_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      cdone_q <= 1'b0;
      prev_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      mode_q  <= '0;
      level_q <= '0;
      shots_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_i;
      cdone_q <= capture_done_i;
      prev_q  <= trig_sample_i;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      if (latch) begin
        mode_q  <= mode_i;
        level_q <= trig_level_i;
        shots_q <= shots_i;
        hold_q  <= holdoff_i;
      end
    end
  end

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  always_ff @(posedge pdh_clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q  <= '0;
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
      if (latch) tmo_q <= timeout_i;
    end
  end
  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign capture_enable_o = en_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign shots_done_o     = cnt_q;
  assign state_o          = state_q;

endmodule
